motoro3_step_sequencer: RTL and testbench

//  Commutation step sequencer that sits directly upstream of each motoro3_line_generator.

---
 rtl/motoro3_step_sequencer_pkg.sv | 28 ++
 rtl/motoro3_step_sequencer_if.sv | 23 ++
 rtl/motoro3_step_sequencer_period_counter.sv | 52 +++++
 rtl/motoro3_step_sequencer.sv | 118 +++++++++++
 tb/tb_motoro3_step_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/motoro3_step_sequencer_pkg.sv
// Shared types and constants for the motoro3 commutation step sequencer.
package motoro3_step_sequencer_pkg;

  localparam int unsigned CNT_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    BRAKE = 2'd3
  } state_e;

  localparam logic [3:0] STEP_OFF   = 4'd0;
  localparam logic [3:0] STEP_FIRST = 4'd1;
  localparam logic [3:0] STEP_LAST  = 4'd6;
  localparam logic [3:0] STEP_BRAKE = 4'd8;

  localparam logic [CNT_W-1:0] MIN_PERIOD_DEF    = 25'd1000;
  localparam logic [7:0]       ALIGN_PERIODS_DEF = 8'd20;
  localparam logic [7:0]       BRAKE_PERIODS_DEF = 8'd10;

  // Next commutation step in the 1..6 ring; dir=1 walks up, dir=0 walks down.
  function automatic logic [3:0] step_advance(input logic [3:0] step, input logic dir);
    if (dir) return (step == STEP_LAST) ? STEP_FIRST : step + 4'd1;
    else     return (step == STEP_FIRST) ? STEP_LAST : step - 4'd1;
  endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// Control/status bundle between the motor register block and the step sequencer.
interface motoro3_step_sequencer_if;

  logic                                        m3r_start;
  logic                                        m3r_stop;
  logic                                        m3r_dir;
  logic [motoro3_step_sequencer_pkg::CNT_W-1:0] m3r_stepCNT_speedSET;
  logic [3:0]                                  m3step;
  logic [motoro3_step_sequencer_pkg::CNT_W-1:0] m3cnt;
  logic                                        m3cntLast1;
  logic                                        m3busy;

  modport master (
    output m3r_start, m3r_stop, m3r_dir, m3r_stepCNT_speedSET,
    input  m3step, m3cnt, m3cntLast1, m3busy
  );

  modport slave (
    input  m3r_start, m3r_stop, m3r_dir, m3r_stepCNT_speedSET,
    output m3step, m3cnt, m3cntLast1, m3busy
  );

endinterface

// File: rtl/motoro3_step_sequencer_period_counter.sv
// Per-step period counter: clamped period register, cycle index and registered
// last-cycle strobe aligned with cnt == period-1.
module motoro3_period_counter
  import motoro3_step_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             newPeriod_i,
  input  logic [CNT_W-1:0] speed_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] speed_clamped;

  // Next period/count; the strobe is precomputed against the period that the
  // next cycle will run with, so a reload at the wrap is honoured from cnt=0.
  always_comb begin
    speed_clamped = (speed_i < MIN_PERIOD) ? MIN_PERIOD : speed_i;
    period_d      = newPeriod_i ? speed_clamped : period_q;
    cnt_d         = '0;
    last_d        = 1'b0;
    if (!clear_i && run_i) begin
      cnt_d  = last_q ? '0 : cnt_q + 1'b1;
      last_d = (cnt_d == period_d - 1'b1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      period_q <= MIN_PERIOD;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last_q;

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: IDLE -> ALIGN -> RUN -> BRAKE -> IDLE, stepping
// the 6-step sequence once per period; drives lgStep of the line generators.
module motoro3_step_sequencer
  import motoro3_step_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] MIN_PERIOD    = MIN_PERIOD_DEF,
  parameter logic [7:0]       ALIGN_PERIODS = ALIGN_PERIODS_DEF,
  parameter logic [7:0]       BRAKE_PERIODS = BRAKE_PERIODS_DEF
) (
  input  logic                     clk,
  input  logic                     nRst,
  motoro3_step_sequencer_if.slave  m3
);

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [7:0]       phase_q, phase_d;
  logic             busy_q;
  logic             clear, run, newPeriod;
  logic [CNT_W-1:0] cnt;
  logic             last;

  motoro3_period_counter #(
    .MIN_PERIOD (MIN_PERIOD)
  ) u_period_counter (
    .clk         (clk),
    .nRst        (nRst),
    .clear_i     (clear),
    .run_i       (run),
    .newPeriod_i (newPeriod),
    .speed_i     (m3.m3r_stepCNT_speedSET),
    .cnt_o       (cnt),
    .last_o      (last)
  );

  // Next-state, step and counter control; stop takes effect immediately,
  // every other transition waits for the period boundary.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    phase_d   = phase_q;
    clear     = 1'b0;
    newPeriod = 1'b0;
    run       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (m3.m3r_start && !m3.m3r_stop) begin
          state_d   = ALIGN;
          step_d    = STEP_FIRST;
          phase_d   = '0;
          clear     = 1'b1;
          newPeriod = 1'b1;
        end
      end
      ALIGN, RUN: begin
        if (m3.m3r_stop) begin
          state_d = BRAKE;
          step_d  = STEP_BRAKE;
          phase_d = '0;
          clear   = 1'b1;
        end else if (last) begin
          newPeriod = 1'b1;
          if (state_q == ALIGN) begin
            if (phase_q == ALIGN_PERIODS - 8'd1) begin
              state_d = RUN;
              step_d  = m3.m3r_dir ? 4'd2 : 4'd6;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 8'd1;
            end
          end else begin
            step_d = step_advance(step_q, m3.m3r_dir);
          end
        end
      end
      BRAKE: begin
        if (last) begin
          newPeriod = 1'b1;
          if (phase_q == BRAKE_PERIODS - 8'd1) begin
            state_d = IDLE;
            step_d  = STEP_OFF;
            phase_d = '0;
            clear   = 1'b1;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = STEP_OFF;
        phase_d = '0;
        clear   = 1'b1;
      end
    endcase
  end

  // FSM, step and busy registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      step_q  <= STEP_OFF;
      phase_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign m3.m3step     = step_q;
  assign m3.m3cnt      = cnt;
  assign m3.m3cntLast1 = last;
  assign m3.m3busy     = busy_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer (shortened periods via overrides:
// MIN_PERIOD=100, ALIGN_PERIODS=4, BRAKE_PERIODS=3).
module tb_motoro3_step_sequencer;

  localparam int unsigned LIMIT = 20000;

  typedef struct {
    logic [3:0]  step;
    logic [24:0] cnt;
    logic        last;
    logic        busy;
    int unsigned len;
  } ev_t;

  logic clk = 1'b0;
  logic nRst = 1'b1;
  bit   done = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  motoro3_step_sequencer_if bus();

  motoro3_step_sequencer #(
    .MIN_PERIOD    (25'd100),
    .ALIGN_PERIODS (8'd4),
    .BRAKE_PERIODS (8'd3)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .m3   (bus)
  );

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [24:0] c, input logic l,
                      input logic b, input int unsigned len);
    ev_t e;
    e.step = s; e.cnt = c; e.last = l; e.busy = b; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic step_start(input logic [3:0] s);
    push(s, 25'd0, 1'b0, 1'b1, 0);
  endtask

  task automatic pulse(input logic [3:0] s, input int unsigned p);
    push(s, 25'(p - 1), 1'b1, 1'b1, p);
  endtask

  task automatic to_idle();
    push(4'd0, 25'd0, 1'b0, 1'b0, 0);
  endtask

  // Stimulus: pushes the full expected event transcript, then drives inputs.
  initial begin : stimulus
    bus.m3r_start = 1'b0;
    bus.m3r_stop  = 1'b0;
    bus.m3r_dir   = 1'b1;
    bus.m3r_stepCNT_speedSET = 25'd200;
    #1;
    nRst = 1'b0;
    to_idle();                       // reset state
    tick(3);
    nRst = 1'b1;
    tick(2);

    // Run 1: period 200, dir=1; at step 3 switch to period 300 and dir=0.
    step_start(4'd1);
    repeat (4) pulse(4'd1, 200);
    step_start(4'd2); pulse(4'd2, 200);
    step_start(4'd3); pulse(4'd3, 200);   // current period not stretched
    step_start(4'd2); pulse(4'd2, 300);
    step_start(4'd1); pulse(4'd1, 300);
    step_start(4'd6); pulse(4'd6, 300);   // 1 wraps to 6
    step_start(4'd5); pulse(4'd5, 300);
    step_start(4'd4); pulse(4'd4, 100);   // speedSET=10 clamped
    step_start(4'd3);
    push(4'd8, 25'd0, 1'b0, 1'b1, 0);     // start+stop in RUN -> BRAKE
    repeat (3) pulse(4'd8, 100);
    to_idle();

    bus.m3r_start = 1'b1;
    tick(1);                               // k=0: ALIGN, cnt=0
    bus.m3r_start = 1'b0;
    tick(1100);
    bus.m3r_stepCNT_speedSET = 25'd300;
    bus.m3r_dir = 1'b0;
    tick(1100);
    bus.m3r_stepCNT_speedSET = 25'd10;
    tick(350);
    bus.m3r_start = 1'b1;
    bus.m3r_stop  = 1'b1;
    tick(1);
    bus.m3r_start = 1'b0;
    bus.m3r_stop  = 1'b0;
    tick(150);
    bus.m3r_start = 1'b1;                  // ignored in BRAKE
    tick(1);
    bus.m3r_start = 1'b0;
    tick(200);
    bus.m3r_stop = 1'b1;                   // ignored in IDLE
    tick(1);
    bus.m3r_stop = 1'b0;
    tick(20);

    // Run 2: period exactly at the clamp, dir=1, wrap 6->1, then async reset.
    bus.m3r_stepCNT_speedSET = 25'd100;
    bus.m3r_dir = 1'b1;
    step_start(4'd1);
    repeat (4) pulse(4'd1, 100);
    step_start(4'd2); pulse(4'd2, 100);
    step_start(4'd3); pulse(4'd3, 100);
    step_start(4'd4); pulse(4'd4, 100);
    step_start(4'd5); pulse(4'd5, 100);
    step_start(4'd6); pulse(4'd6, 100);
    step_start(4'd1);
    to_idle();                             // reset mid-RUN
    bus.m3r_start = 1'b1;
    tick(1);
    bus.m3r_start = 1'b0;
    tick(940);
    nRst = 1'b0;
    tick(3);
    nRst = 1'b1;
    tick(50);
    bus.m3r_start = 1'b1;                  // start+stop in IDLE: ignored
    bus.m3r_stop  = 1'b1;
    tick(1);
    bus.m3r_start = 1'b0;
    bus.m3r_stop  = 1'b0;
    tick(20);

    // Run 3: stop during ALIGN; brake uses the period sampled at start.
    bus.m3r_stepCNT_speedSET = 25'd120;
    step_start(4'd1);
    push(4'd8, 25'd0, 1'b0, 1'b1, 0);
    repeat (3) pulse(4'd8, 120);
    to_idle();
    bus.m3r_start = 1'b1;
    tick(1);
    bus.m3r_start = 1'b0;
    tick(30);
    bus.m3r_stop = 1'b1;
    tick(1);
    bus.m3r_stop = 1'b0;
    tick(400);
    done = 1'b1;
  end

  // Monitor: an event is any strobe, step change or busy change; each is
  // checked against the next expected record.
  initial begin : monitor
    ev_t         e;
    int unsigned len;
    int unsigned cyc;
    int unsigned nev;
    logic [3:0]  prev_step;
    logic        prev_busy;
    bit          have_prev;
    len = 0; cyc = 0; nev = 0; prev_step = '0; prev_busy = 1'b0; have_prev = 1'b0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (bus.m3cnt == '0) len = 1;
      else len++;
      if (!have_prev || bus.m3cntLast1 || bus.m3step != prev_step || bus.m3busy != prev_busy) begin
        nev++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event%0d: got step=%0d cnt=%0d last=%0d busy=%0d, expected no event",
                   nev, bus.m3step, bus.m3cnt, bus.m3cntLast1, bus.m3busy);
        end else begin
          e = exp_q.pop_front();
          if (bus.m3step !== e.step || bus.m3cnt !== e.cnt ||
              bus.m3cntLast1 !== e.last || bus.m3busy !== e.busy) begin
            errors++;
            $display("FAIL event%0d: got step=%0d cnt=%0d last=%0d busy=%0d, expected step=%0d cnt=%0d last=%0d busy=%0d",
                     nev, bus.m3step, bus.m3cnt, bus.m3cntLast1, bus.m3busy,
                     e.step, e.cnt, e.last, e.busy);
          end
          if (e.last) begin
            checks++;
            if (len != e.len) begin
              errors++;
              $display("FAIL period_event%0d: got %0d cycles, expected %0d", nev, len, e.len);
            end
          end
        end
      end
      have_prev = 1'b1;
      prev_step = bus.m3step;
      prev_busy = bus.m3busy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles without completion, expected under %0d", cyc, LIMIT);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_events: got 0 further events, expected %0d more", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
